// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response channel of the load/store unit.
// The master drives requests, the slave (load_store_unit) answers with one response per request.
interface load_store_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic [RD_W-1:0] req_rd_i;
  logic            resp_valid_o;
  logic [XLEN-1:0] resp_rdata_o;
  logic [RD_W-1:0] resp_rd_o;
  logic            resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: alignment check, sub-word load extraction and
// read-modify-write sub-word stores against a word-write-only data memory.
module load_store_unit #(
  parameter int unsigned DM_ADDR_WIDTH = 32
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_i,
  load_store_unit_if.slave         req_if,
  output logic                     dm_wr_en_o,
  output logic                     dm_rd_en_o,
  output logic [DM_ADDR_WIDTH-1:0] dm_addr_o,
  output logic [31:0]              dm_wdata_o,
  input  logic [31:0]              dm_rdata_i
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LD_REQ   = 3'd1;
  localparam logic [2:0] LD_DATA  = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_MERGE = 3'd4;
  localparam logic [2:0] ST_WR    = 3'd5;
  localparam logic [2:0] RESP     = 3'd6;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [2:0]      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            ready_q, ready_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [RD_W-1:0] resp_rd_q, resp_rd_d;

  logic            req_illegal;
  logic            req_misaligned;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] st_merge;

  // Request decode: illegal funct3 and natural-alignment check
  always_comb begin
    if (req_if.req_we_i) begin
      req_illegal = (req_if.req_funct3_i > F3_W);
    end else begin
      req_illegal = (req_if.req_funct3_i == 3'b011) || (req_if.req_funct3_i == 3'b110) ||
                    (req_if.req_funct3_i == 3'b111);
    end
    case (req_if.req_funct3_i[1:0])
      2'b01:   req_misaligned = req_if.req_addr_i[0];
      2'b10:   req_misaligned = (req_if.req_addr_i[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  // Load lane extraction and store lane merge over the returned memory word
  always_comb begin
    ld_byte = dm_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (funct3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_ext = dm_rdata_i;
      F3_BU:   ld_ext = {24'd0, ld_byte};
      F3_HU:   ld_ext = {16'd0, ld_half};
      default: ld_ext = '0;
    endcase
    st_merge = dm_rdata_i;
    if (funct3_q == F3_H) begin
      st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    ready_d      = 1'b0;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    resp_rd_d    = '0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_if.req_valid_i) begin
          ready_d  = 1'b0;
          we_d     = req_if.req_we_i;
          funct3_d = req_if.req_funct3_i;
          addr_d   = req_if.req_addr_i;
          wdata_d  = req_if.req_wdata_i;
          rd_d     = req_if.req_rd_i;
          if (req_illegal || req_misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_if.req_we_i) begin
            state_d = LD_REQ;
            rd_en_d = 1'b1;
          end else if (req_if.req_funct3_i == F3_W) begin
            state_d = ST_WR;
            wr_en_d = 1'b1;
          end else begin
            state_d = ST_RD;
            rd_en_d = 1'b1;
          end
        end
      end
      LD_REQ:  state_d = LD_DATA;
      LD_DATA: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_ext;
        resp_rd_d    = rd_q;
      end
      ST_RD:   state_d = ST_MERGE;
      ST_MERGE: begin
        state_d = ST_WR;
        wdata_d = st_merge;
        wr_en_d = 1'b1;
      end
      ST_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      ready_q      <= 1'b1;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      ready_q      <= ready_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  assign req_if.req_ready_o  = ready_q;
  assign req_if.resp_valid_o = resp_valid_q;
  assign req_if.resp_err_o   = resp_err_q;
  assign req_if.resp_rdata_o = resp_rdata_q;
  assign req_if.resp_rd_o    = resp_rd_q;

  assign dm_rd_en_o = rd_en_q;
  assign dm_wr_en_o = wr_en_q;
  assign dm_addr_o  = DM_ADDR_WIDTH'(addr_q[31:2]);
  assign dm_wdata_o = wdata_q;

  // The unit only ever needs the latched opcode type through funct3/state
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus randomized traffic
// against a byte-level reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_wr_en, dm_rd_en;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  int          obs_lat, rd_pulses, wr_pulses;
  bit          overlap, busy_ready;
  logic        obs_err;
  logic [31:0] obs_rdata, wr_addr_seen, wr_data_seen;
  logic [4:0]  obs_rd;

  load_store_unit_if bus ();

  load_store_unit #(.DM_ADDR_WIDTH(32)) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .req_if    (bus.slave),
    .dm_wr_en_o(dm_wr_en),
    .dm_rd_en_o(dm_rd_en),
    .dm_addr_o (dm_addr),
    .dm_wdata_o(dm_wdata),
    .dm_rdata_i(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, word write, plus a backdoor preload port
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (dm_wr_en) mem[dm_addr[7:0]] <= dm_wdata;
    if (dm_rd_en) dm_rdata <= mem[dm_addr[7:0]];
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference: behaviour from access size/sign rules over a byte-addressed view
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       output logic e_err, output logic [31:0] e_rdata, output logic [4:0] e_rd,
                       output int e_lat, output int e_rdp, output int e_wrp);
    int size = 4;
    bit sgn = 0, ill = 0;
    int off = int'(addr % 4);
    logic [31:0] word = ref_mem[addr[9:2]];
    logic [63:0] mask, val;
    if (!we) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: ill = 1;
      endcase
    end else begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: ill = 1;
      endcase
    end
    e_err = ill || ((addr % size) != 0);
    e_rdata = '0; e_rd = '0; e_rdp = 0; e_wrp = 0;
    if (e_err) begin
      e_lat = 1;
    end else if (!we) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      val  = (64'(word) >> (8 * off)) & mask;
      if (sgn && val[8 * size - 1]) val = val | ~mask;
      e_rdata = val[31:0];
      e_rd = rd; e_lat = 3; e_rdp = 1;
    end else begin
      for (int i = 0; i < size; i++) word[8 * (off + i) +: 8] = wdata[8 * i +: 8];
      ref_mem[addr[9:2]] = word;
      e_lat = (size == 4) ? 2 : 4;
      e_rdp = (size == 4) ? 0 : 1;
      e_wrp = 1;
    end
  endtask

  // Drive one request and record what the unit did until its response
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    int guard = 0;
    while (!bus.req_ready_o && guard < 20) begin @(posedge clk); #1; guard++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_funct3_i = f3;
    bus.req_addr_i = addr; bus.req_wdata_i = wdata; bus.req_rd_i = rd;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    obs_lat = -1; rd_pulses = 0; wr_pulses = 0; overlap = 0; busy_ready = 0;
    obs_err = 1'bx; obs_rdata = 'x; obs_rd = 'x; wr_addr_seen = 'x; wr_data_seen = 'x;
    for (int n = 1; n <= 8; n++) begin
      if (dm_rd_en) rd_pulses++;
      if (dm_wr_en) begin wr_pulses++; wr_addr_seen = dm_addr; wr_data_seen = dm_wdata; end
      if (dm_rd_en && dm_wr_en) overlap = 1;
      if (bus.req_ready_o) busy_ready = 1;
      if (bus.resp_valid_o) begin
        obs_lat = n; obs_err = bus.resp_err_o; obs_rdata = bus.resp_rdata_o; obs_rd = bus.resp_rd_o;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bd_we = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_funct3_i = '0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_rd_i = '0;
    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    rst = 1'b0;
    n_cmp++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, dm_wr_en, dm_rd_en} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 10000",
        {bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, dm_wr_en, dm_rd_en});
    end
    n_cmp++;
    if ({bus.resp_rdata_o, bus.resp_rd_o, dm_addr, dm_wdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: rdata %h rd %h addr %h wdata %h want all 0",
        bus.resp_rdata_o, bus.resp_rd_o, dm_addr, dm_wdata);
    end
  endtask

  task automatic test_sw();
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd7);
    ref_mem[8'h40] = 32'hDEADBEEF;
    n_cmp++;
    if (wr_pulses !== 1 || wr_addr_seen !== 32'h40 || wr_data_seen !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_write: pulses %0d addr %h data %h want 1 00000040 deadbeef",
        wr_pulses, wr_addr_seen, wr_data_seen);
    end
    n_cmp++;
    if (obs_lat !== 2 || obs_err !== 1'b0 || rd_pulses !== 0) begin
      n_bad++; $display("FAIL sw_resp: lat %0d err %b rdp %0d want 2 0 0", obs_lat, obs_err, rd_pulses);
    end
  endtask

  task automatic test_lb_lbu();
    poke(8'h40, 32'h80FF7F01);
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
    n_cmp++;
    if (obs_rdata !== 32'hFFFFFF80 || obs_rd !== 5'd5 || obs_lat !== 3 || obs_err !== 1'b0) begin
      n_bad++; $display("FAIL lb: rdata %h rd %0d lat %0d err %b want ffffff80 5 3 0",
        obs_rdata, obs_rd, obs_lat, obs_err);
    end
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 5'd9);
    n_cmp++;
    if (obs_rdata !== 32'h00000080 || obs_rd !== 5'd9 || obs_lat !== 3) begin
      n_bad++; $display("FAIL lbu: rdata %h rd %0d lat %0d want 00000080 9 3", obs_rdata, obs_rd, obs_lat);
    end
  endtask

  task automatic test_rmw();
    poke(8'h40, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h102, 32'h000000AA, 5'd1);
    n_cmp++;
    if (wr_data_seen !== 32'h11AA3344 || rd_pulses !== 1 || wr_pulses !== 1 || obs_lat !== 4) begin
      n_bad++; $display("FAIL sb_rmw: wdata %h rdp %0d wrp %0d lat %0d want 11aa3344 1 1 4",
        wr_data_seen, rd_pulses, wr_pulses, obs_lat);
    end
    poke(8'h40, 32'h11223344);
    do_req(1'b1, 3'b001, 32'h102, 32'h00005566, 5'd1);
    ref_mem[8'h40] = 32'h55663344;
    n_cmp++;
    if (wr_data_seen !== 32'h55663344 || obs_lat !== 4 || mem[8'h40] !== 32'h55663344) begin
      n_bad++; $display("FAIL sh_rmw: wdata %h lat %0d mem %h want 55663344 4 55663344",
        wr_data_seen, obs_lat, mem[8'h40]);
    end
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 5'd12);
    n_cmp++;
    if (obs_rdata !== 32'h00005566 || obs_rd !== 5'd12) begin
      n_bad++; $display("FAIL lh_pos: rdata %h rd %0d want 00005566 12", obs_rdata, obs_rd);
    end
    poke(8'h41, 32'h80011234);
    do_req(1'b0, 3'b001, 32'h106, 32'h0, 5'd13);
    n_cmp++;
    if (obs_rdata !== 32'hFFFF8001) begin
      n_bad++; $display("FAIL lh_neg: rdata %h want ffff8001", obs_rdata);
    end
  endtask

  task automatic test_errors();
    logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] ad_t [3] = '{32'h101, 32'h103, 32'h100};
    for (int k = 0; k < 3; k++) begin
      do_req(we_t[k], f3_t[k], ad_t[k], 32'hFFFFFFFF, 5'd31);
      n_cmp++;
      if (obs_err !== 1'b1 || obs_lat !== 1 || rd_pulses !== 0 || wr_pulses !== 0 ||
          obs_rdata !== 32'h0 || obs_rd !== 5'd0) begin
        n_bad++; $display("FAIL err_case%0d: err %b lat %0d rdp %0d wrp %0d rdata %h rd %0d want 1 1 0 0 0 0",
          k, obs_err, obs_lat, rd_pulses, wr_pulses, obs_rdata, obs_rd);
      end
    end
  endtask

  task automatic test_reset_mid_rmw();
    int wr_seen = 0, resp_seen = 0, guard = 0;
    poke(8'h40, 32'h11223344);
    while (!bus.req_ready_o && guard < 20) begin @(posedge clk); #1; guard++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b000;
    bus.req_addr_i = 32'h102; bus.req_wdata_i = 32'h000000AA; bus.req_rd_i = 5'd4;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    if (dm_wr_en) wr_seen++;
    @(posedge clk); #1;
    if (dm_wr_en) wr_seen++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, dm_wr_en, dm_rd_en} !== 5'b10000 ||
        {bus.resp_rdata_o, bus.resp_rd_o, dm_addr, dm_wdata} !== '0) begin
      n_bad++; $display("FAIL rst_rmw_outputs: ctrl %b rdata %h addr %h wdata %h want 10000 and zeros",
        {bus.req_ready_o, bus.resp_valid_o, bus.resp_err_o, dm_wr_en, dm_rd_en},
        bus.resp_rdata_o, dm_addr, dm_wdata);
    end
    for (int c = 0; c < 5; c++) begin
      if (dm_wr_en) wr_seen++;
      if (bus.resp_valid_o) resp_seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (wr_seen !== 0 || resp_seen !== 0 || mem[8'h40] !== 32'h11223344) begin
      n_bad++; $display("FAIL rst_rmw_drop: wr %0d resp %0d mem %h want 0 0 11223344",
        wr_seen, resp_seen, mem[8'h40]);
    end
  endtask

  task automatic test_back_to_back();
    logic        e_err0, e_err1;
    logic [31:0] e_rd0, e_rdata1;
    logic [4:0]  e_rdt0, e_rdt1;
    int          l0, l1, rp0, rp1, wp0, wp1;
    int          accepts = 0, acc_cycle = -1, resp_cnt = 0, ld_cycle = -1, rdp = 0, guard = 0;
    logic [31:0] ld_data = 'x;
    logic [4:0]  ld_rd = 'x;
    bit          acc;
    model(1'b1, 3'b010, 32'h140, 32'h12345678, 5'd2, e_err0, e_rd0, e_rdt0, l0, rp0, wp0);
    model(1'b0, 3'b010, 32'h140, 32'h0, 5'd3, e_err1, e_rdata1, e_rdt1, l1, rp1, wp1);
    while (!bus.req_ready_o && guard < 20) begin @(posedge clk); #1; guard++; end
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_funct3_i = 3'b010;
    bus.req_addr_i = 32'h140; bus.req_wdata_i = 32'h12345678; bus.req_rd_i = 5'd2;
    @(posedge clk); #1;
    bus.req_we_i = 1'b0; bus.req_wdata_i = 32'h0; bus.req_rd_i = 5'd3;
    for (int c = 1; c <= 12; c++) begin
      if (dm_rd_en) rdp++;
      if (bus.resp_valid_o) begin
        resp_cnt++;
        if (resp_cnt == 2) begin ld_cycle = c; ld_data = bus.resp_rdata_o; ld_rd = bus.resp_rd_o; end
      end
      acc = bus.req_valid_i && bus.req_ready_o;
      @(posedge clk); #1;
      if (acc) begin accepts++; acc_cycle = c; bus.req_valid_i = 1'b0; end
    end
    bus.req_valid_i = 1'b0;
    n_cmp++;
    if (accepts !== 1 || acc_cycle !== 3 || resp_cnt !== 2 || rdp !== 1) begin
      n_bad++; $display("FAIL held_accept: accepts %0d at %0d resps %0d rdp %0d want 1 3 2 1",
        accepts, acc_cycle, resp_cnt, rdp);
    end
    n_cmp++;
    if (ld_data !== e_rdata1 || ld_rd !== e_rdt1 || ld_cycle !== 3 + l1) begin
      n_bad++; $display("FAIL store_then_load: rdata %h rd %0d cycle %0d want %h %0d %0d",
        ld_data, ld_rd, ld_cycle, e_rdata1, e_rdt1, 3 + l1);
    end
  endtask

  task automatic test_random();
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, e_rdata;
    logic [4:0]  rd, e_rd;
    int          e_lat, e_rdp, e_wrp;
    for (int it = 0; it < 80; it++) begin
      we = 1'($urandom); f3 = 3'($urandom); addr = 32'($urandom_range(0, 1023));
      wdata = $urandom; rd = 5'($urandom);
      if (it % 3 == 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
      model(we, f3, addr, wdata, rd, e_err, e_rdata, e_rd, e_lat, e_rdp, e_wrp);
      do_req(we, f3, addr, wdata, rd);
      n_cmp++;
      if (obs_err !== e_err || obs_rdata !== e_rdata || obs_rd !== e_rd || obs_lat !== e_lat) begin
        n_bad++; $display("FAIL rnd_resp[%0d] we%b f3=%0d a=%h: err %b rdata %h rd %0d lat %0d want %b %h %0d %0d",
          it, we, f3, addr, obs_err, obs_rdata, obs_rd, obs_lat, e_err, e_rdata, e_rd, e_lat);
      end
      n_cmp++;
      if (rd_pulses !== e_rdp || wr_pulses !== e_wrp || overlap || busy_ready ||
          mem[addr[9:2]] !== ref_mem[addr[9:2]]) begin
        n_bad++; $display("FAIL rnd_mem[%0d]: rdp %0d wrp %0d ovl %b busyrdy %b mem %h want %0d %0d 0 0 %h",
          it, rd_pulses, wr_pulses, overlap, busy_ready, mem[addr[9:2]], e_rdp, e_wrp, ref_mem[addr[9:2]]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_lb_lbu();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
